// File: rtl/surf6_fwu_packer.sv
// Packs the firmware byte stream into 32-bit words for the A/B URAM half-buffers and marks each closed half.
// Optional SURF6_FWU_PACKER_CHECKSUM_EN adds checksum_o, a running sum of every word written.
module surf6_fwu_packer #(
    parameter int unsigned HALF_ADDR_BITS = 10
) (
    input  logic                      sysclk_i,
    input  logic                      rst_i,
    input  logic [7:0]                fw_dat_i,
    input  logic                      fw_valid_i,
    output logic                      fw_ready_o,
    input  logic                      fw_flush_i,
    input  logic [1:0]                bank_ready_i,
    output logic                      buf_we_o,
    output logic [HALF_ADDR_BITS:0]   buf_addr_o,
    output logic [31:0]               buf_dat_o,
    output logic [1:0]                fw_mark_o,
    output logic                      overrun_o
`ifdef SURF6_FWU_PACKER_CHECKSUM_EN
    ,
    output logic [31:0]               checksum_o
`endif
);

    localparam int unsigned AW  = HALF_ADDR_BITS;
    localparam int unsigned BAW = HALF_ADDR_BITS + 1;

    localparam logic [1:0] ST_WAIT_BANK = 2'd0;
    localparam logic [1:0] ST_FILL      = 2'd1;
    localparam logic [1:0] ST_MARK      = 2'd2;

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic           cur_half;
    logic           cur_half_nxt;
    logic [AW-1:0]  waddr;
    logic [AW-1:0]  waddr_nxt;
    logic [1:0]     byte_cnt;
    logic [1:0]     byte_cnt_nxt;
    logic [31:0]    pack;
    logic [31:0]    pack_nxt;

    logic           ready_nxt;
    logic           we_nxt;
    logic [BAW-1:0] addr_nxt;
    logic [31:0]    dat_nxt;
    logic [1:0]     mark_nxt;
    logic           overrun_nxt;

    logic           accept;
    logic           word_done;
    logic           last_word;
    logic           flush_go;
    logic           partial_wr;
    logic [31:0]    pack_merged;
    logic [1:0]     cnt_merged;

    // Byte merge and close conditions; a byte arriving with flush is packed first.
    always_comb begin
        accept      = fw_valid_i & fw_ready_o;
        pack_merged = pack;
        cnt_merged  = byte_cnt;
        if (accept) begin
            pack_merged[{byte_cnt, 3'b000} +: 8] = fw_dat_i;
            cnt_merged                           = byte_cnt + 2'd1;
        end
        word_done  = accept && (byte_cnt == 2'd3);
        last_word  = word_done && (&waddr);
        flush_go   = (state == ST_FILL) && fw_flush_i
                     && (word_done || (cnt_merged != 2'd0) || (waddr != '0));
        partial_wr = flush_go && (cnt_merged != 2'd0);
    end

    always_comb begin
        state_nxt    = state;
        cur_half_nxt = cur_half;
        waddr_nxt    = waddr;
        byte_cnt_nxt = byte_cnt;
        pack_nxt     = pack;
        we_nxt       = 1'b0;
        addr_nxt     = buf_addr_o;
        dat_nxt      = buf_dat_o;
        mark_nxt     = 2'b00;
        overrun_nxt  = overrun_o | (fw_valid_i & ~fw_ready_o);

        case (state)
            ST_WAIT_BANK: begin
                if (bank_ready_i[cur_half]) begin
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    byte_cnt_nxt = cnt_merged;
                    pack_nxt     = pack_merged;
                end
                if (word_done || partial_wr) begin
                    we_nxt       = 1'b1;
                    addr_nxt     = {cur_half, waddr};
                    dat_nxt      = pack_merged;
                    waddr_nxt    = waddr + AW'(1);
                    pack_nxt     = 32'd0;
                    byte_cnt_nxt = 2'd0;
                end
                if (last_word || flush_go) begin
                    state_nxt = ST_MARK;
                end
            end
            ST_MARK: begin
                // Final write of the half is on the bus now; close it and move on.
                mark_nxt     = cur_half ? 2'b10 : 2'b01;
                cur_half_nxt = ~cur_half;
                waddr_nxt    = '0;
                state_nxt    = ST_WAIT_BANK;
            end
            default: begin
                state_nxt = ST_WAIT_BANK;
            end
        endcase

        ready_nxt = (state_nxt == ST_FILL);
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state      <= ST_WAIT_BANK;
            cur_half   <= 1'b0;
            waddr      <= '0;
            byte_cnt   <= 2'd0;
            pack       <= 32'd0;
            fw_ready_o <= 1'b0;
            buf_we_o   <= 1'b0;
            buf_addr_o <= '0;
            buf_dat_o  <= 32'd0;
            fw_mark_o  <= 2'b00;
            overrun_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_half   <= cur_half_nxt;
            waddr      <= waddr_nxt;
            byte_cnt   <= byte_cnt_nxt;
            pack       <= pack_nxt;
            fw_ready_o <= ready_nxt;
            buf_we_o   <= we_nxt;
            buf_addr_o <= addr_nxt;
            buf_dat_o  <= dat_nxt;
            fw_mark_o  <= mark_nxt;
            overrun_o  <= overrun_nxt;
        end
    end

`ifdef SURF6_FWU_PACKER_CHECKSUM_EN
    logic [31:0] checksum_nxt;

    // Accumulates each word the cycle after it is presented to the buffer.
    always_comb begin
        checksum_nxt = checksum_o;
        if (buf_we_o) begin
            checksum_nxt = checksum_o + buf_dat_o;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            checksum_o <= 32'd0;
        end else begin
            checksum_o <= checksum_nxt;
        end
    end
`endif

endmodule
